sgpr_ckpt: RTL and testbench
============================

# sgpr_ckpt

Parametrised general-purpose register file with an integrated checkpoint/rollback engine for the fault-tolerant core. It generalises the single-write, two-read `sgpr` to configurable width, depth and read-port count, and adds a shadow bank. The shadow bank is filled by a checkpoint sequence and copied back by a rollback sequence. It sits in the decode stage and its control ports are driven by the fault-recovery controller.

## Interface

Parameters:
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: address width; `DEPTH = 2**ADDR_WIDTH` registers.
- `NUM_RD`, 2: number of combinational read ports, range 1..4.
- `ZERO_REG`, 1: when 1, register 0 reads 0 and ignores writes in both banks.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `test_en_i` in 1: clock-gate test enable; no functional effect.
- `raddr_i` in NUM_RD×ADDR_WIDTH: read addresses; port k uses slice k.
- `rdata_o` out NUM_RD×DATA_WIDTH: read data from the working bank.
- `waddr_i` in ADDR_WIDTH: write address.
- `wdata_i` in DATA_WIDTH: write data.
- `we_i` in 1: write enable.
- `ckpt_req_i` in 1: single-cycle checkpoint request.
- `rb_req_i` in 1: single-cycle rollback request.
- `busy_o` out 1: a copy sequence is in progress.
- `done_o` out 1: one-cycle pulse when a sequence completes.
- `ckpt_valid_o` out 1: the shadow bank holds a complete checkpoint.
- `wr_drop_o` out 1: one-cycle pulse marking a write discarded because the block was busy.
- `rb_err_o` out 1: one-cycle pulse marking a rollback requested with no valid checkpoint.

## Operation

- **Reset** (`rst_n`=0 at a rising edge):
  - All working and shadow registers become 0.
  - FSM goes to IDLE, index counter becomes 0.
  - `busy_o`, `done_o`, `ckpt_valid_o`, `wr_drop_o` and `rb_err_o` are all 0.
  - Reset mid-sequence aborts the sequence with the same result.
- **Reads:**
  - Combinational from the working bank.
  - No write-to-read bypass: a written value is visible the cycle after the write edge.
  - Reads are valid in all states; during ROLLBACK they return partially restored contents.
- **Writes:**
  - In IDLE, `we_i` writes `wdata_i` to `waddr_i` at the edge.
  - Address 0 is discarded when `ZERO_REG`=1.
- **FSM states:** IDLE, CKPT, ROLLBACK.
  - IDLE with `rb_req_i` and `ckpt_valid_o`=1 → ROLLBACK.
  - IDLE with `rb_req_i` and `ckpt_valid_o`=0 → stay in IDLE and pulse `rb_err_o`.
  - IDLE with `ckpt_req_i` and no `rb_req_i` → CKPT.
  - If `rb_req_i` and `ckpt_req_i` are both high, rollback wins.
  - Entering CKPT or ROLLBACK clears the index to 0.
- **CKPT:** each cycle `shadow[idx] <= work[idx]`, then `idx` increments.
  - When `idx` = DEPTH-1: → IDLE, `done_o` pulses, `ckpt_valid_o` is set.
  - `ckpt_valid_o` is cleared on CKPT entry, so an interrupted checkpoint is never valid.
- **ROLLBACK:** each cycle `work[idx] <= shadow[idx]`, then `idx` increments.
  - When `idx` = DEPTH-1: → IDLE, `done_o` pulses.
  - `ckpt_valid_o` stays 1, so rollback may be repeated.
- **Accept cycle:** a write in the same cycle as an accepted request is performed, and is therefore included in a checkpoint.
- **While busy:**
  - `we_i` is ignored and `wr_drop_o` pulses in the same cycle (registered, visible the next cycle).
  - `ckpt_req_i` and `rb_req_i` are ignored, with no queuing and no error pulse.
- **Index wrap:** the counter is ADDR_WIDTH bits. The terminal test is `idx == DEPTH-1`; the counter never wraps to drive a copy.

## Timing

- Request sampled at edge t: `busy_o`=1 in cycles t+1 … t+DEPTH (32 cycles by default).
- In cycle t+1+DEPTH: `busy_o`=0 and `done_o`=1 for exactly one cycle.
- A new request is accepted in the `done_o` cycle.
- Copy of index i occurs at the edge ending cycle t+1+i.
- `wr_drop_o` and `rb_err_o` are asserted in the cycle after the offending input edge, for one cycle.
- Read latency is 0 cycles (combinational); write latency is 1 edge.

## Structure

- Package `sgpr_pkg` holds:
  - `sgpr_state_e` with values IDLE, CKPT and ROLLBACK.
  - Default width and depth localparams.
- Sub-module `sgpr_bank`, instanced twice (working and shadow):
  - Parametrised storage array.
  - One synchronous write port.
  - `NUM_RD`+1 combinational read ports; the extra port feeds the copy path.
  - Honours `ZERO_REG`.
- Top level holds the FSM, index counter, write muxing and pulse flags.

## Test plan

- **Basic write/read:** write 100 to r10, then read r10 on all ports next cycle → 100. Write 5 to r0 → r0 reads 0.
- **Checkpoint and rollback:** write r10=100 and pulse `ckpt_req_i`.
  - `busy_o` stays high for 32 cycles, then `done_o` and `ckpt_valid_o`=1.
  - Write r10=7 and pulse `rb_req_i`; after 32 busy cycles r10 reads 100.
- **Busy write drop:** write r3=55 during CKPT → `wr_drop_o` pulse; r3 keeps its old value after `done_o`.
- **Rollback error and priority:**
  - `rb_req_i` right after reset → `rb_err_o` pulse and state stays IDLE.
  - `ckpt_req_i` and `rb_req_i` together with a valid checkpoint → rollback runs.
- **Reset mid-checkpoint:** assert `rst_n`=0 at cycle 10 of CKPT.
  - All registers read 0.
  - `busy_o` and `ckpt_valid_o` are 0; a following rollback gives `rb_err_o`.
- **Accept-cycle write:** write r31=0xDEADBEEF in the same cycle as `ckpt_req_i`, overwrite r31 after `done_o`, then roll back → r31 reads 0xDEADBEEF.

Source files
------------

// File: rtl/sgpr_ckpt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sgpr_pkg
// Purpose : Shared types and default sizes for the checkpointing register
//           file (sgpr_ckpt) and its storage banks.
// Contents: sgpr_state_e   - copy-engine FSM states
//           SGPR_*         - default width / depth / read-port count
// Rev     : 1.0 - initial release
// ============================================================================
package sgpr_pkg;

  localparam int SGPR_DATA_WIDTH = 32;
  localparam int SGPR_ADDR_WIDTH = 5;
  localparam int SGPR_NUM_RD     = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CKPT     = 2'd1,
    ROLLBACK = 2'd2
  } sgpr_state_e;

endpackage
`default_nettype wire

// File: rtl/sgpr_ckpt_if.sv
`default_nettype none
// ============================================================================
// Module  : sgpr_ckpt_if
// Purpose : Register-file access and recovery-control bundle for sgpr_ckpt.
// Ports   : test_en_i            clock-gate test enable (no functional use)
//           raddr_i / rdata_o    NUM_RD combinational read ports (flattened)
//           waddr_i/wdata_i/we_i single write port
//           ckpt_req_i/rb_req_i  checkpoint / rollback requests
//           busy_o/done_o/ckpt_valid_o/wr_drop_o/rb_err_o  status
// Modports: master - fault-recovery controller / decode side
//           slave  - the register file
// Rev     : 1.0 - initial release
// ============================================================================
interface sgpr_ckpt_if
  import sgpr_pkg::*;
#(
  parameter int DATA_WIDTH = SGPR_DATA_WIDTH,
  parameter int ADDR_WIDTH = SGPR_ADDR_WIDTH,
  parameter int NUM_RD     = SGPR_NUM_RD
);

  logic                         test_en_i;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_o;
  logic [ADDR_WIDTH-1:0]        waddr_i;
  logic [DATA_WIDTH-1:0]        wdata_i;
  logic                         we_i;
  logic                         ckpt_req_i;
  logic                         rb_req_i;
  logic                         busy_o;
  logic                         done_o;
  logic                         ckpt_valid_o;
  logic                         wr_drop_o;
  logic                         rb_err_o;

  modport master (
    output test_en_i, raddr_i, waddr_i, wdata_i, we_i, ckpt_req_i, rb_req_i,
    input  rdata_o, busy_o, done_o, ckpt_valid_o, wr_drop_o, rb_err_o
  );

  modport slave (
    input  test_en_i, raddr_i, waddr_i, wdata_i, we_i, ckpt_req_i, rb_req_i,
    output rdata_o, busy_o, done_o, ckpt_valid_o, wr_drop_o, rb_err_o
  );

endinterface
`default_nettype wire

// File: rtl/sgpr_ckpt_bank.sv
`default_nettype none
// ============================================================================
// Module  : sgpr_bank
// Purpose : Register storage array with one synchronous write port and
//           NUM_RP combinational read ports. Register 0 is hard-wired to
//           zero when ZERO_REG is set.
// Ports   : clk, rst_n            clock, synchronous active-low reset
//           we_i, waddr_i, wdata_i write port
//           raddr_i / rdata_o      flattened read ports, port k = slice k
// Rev     : 1.0 - initial release
// ============================================================================
module sgpr_bank
  import sgpr_pkg::*;
#(
  parameter int DATA_WIDTH = SGPR_DATA_WIDTH,
  parameter int ADDR_WIDTH = SGPR_ADDR_WIDTH,
  parameter int NUM_RP     = SGPR_NUM_RD + 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we_i,
  input  logic [ADDR_WIDTH-1:0]        waddr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [NUM_RP*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RP*DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i && !((ZERO_REG != 0) && (waddr_i == '0))) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Register 0 is forced to zero on the read side as well, so the storage
  // slot never matters even if it were somehow loaded.
  for (genvar k = 0; k < NUM_RP; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] =
      ((ZERO_REG != 0) && (ra == '0)) ? '0 : mem_q[ra];
  end

endmodule
`default_nettype wire

// File: rtl/sgpr_ckpt.sv
`default_nettype none
// ============================================================================
// Module  : sgpr_ckpt
// Purpose : Register file with a shadow bank. A checkpoint copies the
//           working bank into the shadow bank one register per cycle; a
//           rollback copies it back. Writes arriving while a copy runs are
//           dropped and flagged.
// Ports   : clk, rst_n  clock, synchronous active-low reset
//           bus         sgpr_ckpt_if.slave (reads, write, requests, status)
// Rev     : 1.0 - initial release
// ============================================================================
module sgpr_ckpt
  import sgpr_pkg::*;
#(
  parameter int DATA_WIDTH = SGPR_DATA_WIDTH,
  parameter int ADDR_WIDTH = SGPR_ADDR_WIDTH,
  parameter int NUM_RD     = SGPR_NUM_RD,
  parameter int ZERO_REG   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  sgpr_ckpt_if.slave  bus
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam int                    NUM_RP   = NUM_RD + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  sgpr_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ckpt_valid_q, ckpt_valid_d;
  logic                  done_q, done_d;
  logic                  wr_drop_q, wr_drop_d;
  logic                  rb_err_q, rb_err_d;

  logic                  work_we, shadow_we;
  logic [ADDR_WIDTH-1:0] work_waddr;
  logic [DATA_WIDTH-1:0] work_wdata, work_copy, shadow_copy;

  logic [NUM_RP*ADDR_WIDTH-1:0] bank_raddr;
  logic [NUM_RP*DATA_WIDTH-1:0] work_rdata, shadow_rdata;
  logic [NUM_RD*DATA_WIDTH-1:0] unused_shadow_rd;
  logic                         unused_test_en;

  // The extra top read port of each bank follows the copy index.
  assign bank_raddr       = {idx_q, bus.raddr_i};
  assign bus.rdata_o      = work_rdata[NUM_RD*DATA_WIDTH-1:0];
  assign work_copy        = work_rdata[NUM_RD*DATA_WIDTH +: DATA_WIDTH];
  assign shadow_copy      = shadow_rdata[NUM_RD*DATA_WIDTH +: DATA_WIDTH];
  assign unused_shadow_rd = shadow_rdata[NUM_RD*DATA_WIDTH-1:0];
  assign unused_test_en   = bus.test_en_i;

  sgpr_bank #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_RP(NUM_RP), .ZERO_REG(ZERO_REG)
  ) u_work (
    .clk(clk), .rst_n(rst_n),
    .we_i(work_we), .waddr_i(work_waddr), .wdata_i(work_wdata),
    .raddr_i(bank_raddr), .rdata_o(work_rdata)
  );

  sgpr_bank #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_RP(NUM_RP), .ZERO_REG(ZERO_REG)
  ) u_shadow (
    .clk(clk), .rst_n(rst_n),
    .we_i(shadow_we), .waddr_i(idx_q), .wdata_i(work_copy),
    .raddr_i(bank_raddr), .rdata_o(shadow_rdata)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ckpt_valid_d = ckpt_valid_q;
    done_d       = 1'b0;
    wr_drop_d    = 1'b0;
    rb_err_d     = 1'b0;
    work_we      = 1'b0;
    work_waddr   = bus.waddr_i;
    work_wdata   = bus.wdata_i;
    shadow_we    = 1'b0;

    case (state_q)
      IDLE: begin
        // The accept-cycle write still lands, so it is part of the copy.
        work_we = bus.we_i;
        if (bus.rb_req_i) begin
          if (ckpt_valid_q) begin
            state_d = ROLLBACK;
            idx_d   = '0;
          end else begin
            rb_err_d = 1'b1;
          end
        end else if (bus.ckpt_req_i) begin
          state_d      = CKPT;
          idx_d        = '0;
          ckpt_valid_d = 1'b0;  // an interrupted checkpoint is never valid
        end
      end
      CKPT: begin
        wr_drop_d = bus.we_i;
        shadow_we = 1'b1;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          ckpt_valid_d = 1'b1;
        end
      end
      ROLLBACK: begin
        wr_drop_d  = bus.we_i;
        work_we    = 1'b1;
        work_waddr = idx_q;
        work_wdata = shadow_copy;
        idx_d      = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ckpt_valid_q <= 1'b0;
      done_q       <= 1'b0;
      wr_drop_q    <= 1'b0;
      rb_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ckpt_valid_q <= ckpt_valid_d;
      done_q       <= done_d;
      wr_drop_q    <= wr_drop_d;
      rb_err_q     <= rb_err_d;
    end
  end

  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = done_q;
  assign bus.ckpt_valid_o = ckpt_valid_q;
  assign bus.wr_drop_o    = wr_drop_q;
  assign bus.rb_err_o     = rb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sgpr_ckpt.sv
`default_nettype none
// ============================================================================
// Module  : tb_sgpr_ckpt
// Purpose : Directed self-checking bench for sgpr_ckpt (default sizes:
//           32-bit data, 32 registers, 2 read ports, ZERO_REG=1).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_sgpr_ckpt;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   n;

  sgpr_ckpt_if bus ();

  sgpr_ckpt u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a);
    bus.raddr_i = {a, a};
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we_i    = 1'b1;
    bus.waddr_i = a;
    bus.wdata_i = d;
    tick();
    bus.we_i    = 1'b0;
  endtask

  // Counts busy cycles until busy drops, bounded so a stuck FSM still ends.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy_o && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.test_en_i  = 1'b0;
    bus.raddr_i    = '0;
    bus.waddr_i    = '0;
    bus.wdata_i    = '0;
    bus.we_i       = 1'b0;
    bus.ckpt_req_i = 1'b0;
    bus.rb_req_i   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_busy",  32'(bus.busy_o), 32'd0);
    check("rst_done",  32'(bus.done_o), 32'd0);
    check("rst_valid", 32'(bus.ckpt_valid_o), 32'd0);
    check("rst_drop",  32'(bus.wr_drop_o), 32'd0);
    check("rst_rberr", 32'(bus.rb_err_o), 32'd0);
    rd(5'd10);
    check("rst_r10", bus.rdata_o[31:0], 32'd0);

    // Rollback with no checkpoint
    bus.rb_req_i = 1'b1;
    tick();
    bus.rb_req_i = 1'b0;
    check("rberr_pulse", 32'(bus.rb_err_o), 32'd1);
    check("rberr_idle",  32'(bus.busy_o), 32'd0);
    tick();
    check("rberr_clear", 32'(bus.rb_err_o), 32'd0);

    // Basic write/read
    wr(5'd10, 32'd100);
    rd(5'd10);
    check("wr_r10_p0", bus.rdata_o[31:0],  32'd100);
    check("wr_r10_p1", bus.rdata_o[63:32], 32'd100);
    wr(5'd0, 32'd5);
    rd(5'd0);
    check("wr_r0_p0", bus.rdata_o[31:0],  32'd0);
    check("wr_r0_p1", bus.rdata_o[63:32], 32'd0);

    // Checkpoint (r10=100)
    bus.ckpt_req_i = 1'b1;
    tick();
    bus.ckpt_req_i = 1'b0;
    check("ck1_busy", 32'(bus.busy_o), 32'd1);
    wait_idle(n);
    check("ck1_cycles", 32'(n), 32'd32);
    check("ck1_done",   32'(bus.done_o), 32'd1);
    check("ck1_valid",  32'(bus.ckpt_valid_o), 32'd1);
    tick();
    check("ck1_done_clr", 32'(bus.done_o), 32'd0);

    // Rollback restores r10
    wr(5'd10, 32'd7);
    rd(5'd10);
    check("pre_rb_r10", bus.rdata_o[31:0], 32'd7);
    bus.rb_req_i = 1'b1;
    tick();
    bus.rb_req_i = 1'b0;
    wait_idle(n);
    check("rb1_cycles", 32'(n), 32'd32);
    check("rb1_done",   32'(bus.done_o), 32'd1);
    check("rb1_valid",  32'(bus.ckpt_valid_o), 32'd1);
    rd(5'd10);
    check("rb1_r10", bus.rdata_o[63:32], 32'd100);
    rd(5'd0);
    check("rb1_r0", bus.rdata_o[31:0], 32'd0);

    // Busy write drop
    wr(5'd3, 32'd11);
    bus.ckpt_req_i = 1'b1;
    tick();
    bus.ckpt_req_i = 1'b0;
    wr(5'd3, 32'd55);
    check("drop_pulse", 32'(bus.wr_drop_o), 32'd1);
    tick();
    check("drop_clear", 32'(bus.wr_drop_o), 32'd0);
    wait_idle(n);
    check("ck2_cycles", 32'(n), 32'd30);
    check("ck2_done",   32'(bus.done_o), 32'd1);
    rd(5'd3);
    check("drop_r3", bus.rdata_o[31:0], 32'd11);

    // Both requests with a valid checkpoint: rollback wins
    wr(5'd10, 32'd9);
    bus.ckpt_req_i = 1'b1;
    bus.rb_req_i   = 1'b1;
    tick();
    bus.ckpt_req_i = 1'b0;
    bus.rb_req_i   = 1'b0;
    check("prio_busy",  32'(bus.busy_o), 32'd1);
    check("prio_rberr", 32'(bus.rb_err_o), 32'd0);
    wait_idle(n);
    check("prio_cycles", 32'(n), 32'd32);
    rd(5'd10);
    check("prio_r10", bus.rdata_o[31:0], 32'd100);

    // Accept-cycle write is captured by the checkpoint
    bus.we_i       = 1'b1;
    bus.waddr_i    = 5'd31;
    bus.wdata_i    = 32'hDEADBEEF;
    bus.ckpt_req_i = 1'b1;
    tick();
    bus.we_i       = 1'b0;
    bus.ckpt_req_i = 1'b0;
    check("acc_drop", 32'(bus.wr_drop_o), 32'd0);
    wait_idle(n);
    check("acc_done", 32'(bus.done_o), 32'd1);
    wr(5'd31, 32'h12345678);
    rd(5'd31);
    check("acc_ovr_r31", bus.rdata_o[31:0], 32'h12345678);
    bus.rb_req_i = 1'b1;
    tick();
    bus.rb_req_i = 1'b0;
    wait_idle(n);
    rd(5'd31);
    check("acc_rb_r31", bus.rdata_o[63:32], 32'hDEADBEEF);

    // Reset in cycle 10 of a checkpoint
    bus.ckpt_req_i = 1'b1;
    tick();
    bus.ckpt_req_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_busy", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy",  32'(bus.busy_o), 32'd0);
    check("mrst_valid", 32'(bus.ckpt_valid_o), 32'd0);
    check("mrst_done",  32'(bus.done_o), 32'd0);
    rd(5'd10);
    check("mrst_r10", bus.rdata_o[31:0], 32'd0);
    rd(5'd31);
    check("mrst_r31", bus.rdata_o[31:0], 32'd0);
    rd(5'd3);
    check("mrst_r3", bus.rdata_o[63:32], 32'd0);
    bus.rb_req_i = 1'b1;
    tick();
    bus.rb_req_i = 1'b0;
    check("mrst_rberr", 32'(bus.rb_err_o), 32'd1);
    check("mrst_idle",  32'(bus.busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
